// File: rtl/hazard_fwd_tracker.sv
// Forwarding/hazard tracker: follows in-flight destination registers from EX onward,
// registers a per-source forward select for the instruction entering EX, and raises load-use stalls.
module hazard_fwd_tracker #(
    parameter int IDX_W         = 5,
    parameter int NUM_SRC       = 2,
    parameter int DEPTH         = 3,
    parameter int LOAD_DATA_STG = 3,
    parameter int CNT_W         = 16,
    localparam int SEL_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [NUM_SRC*IDX_W-1:0]   id_rs_idx,
    input  logic [IDX_W-1:0]           id_rd_idx,
    input  logic                       id_rd_we,
    input  logic                       id_is_load,
    input  logic                       flush,
    output logic                       stall,
    output logic                       ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
    output logic [CNT_W-1:0]           stall_cnt
);

    logic [DEPTH:1]            v_q,  v_d;
    logic [DEPTH:1]            we_q, we_d;
    logic [DEPTH:1]            ld_q, ld_d;
    logic [DEPTH:1][IDX_W-1:0] rd_q, rd_d;
    logic [NUM_SRC*SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      hit_s;
    logic                      stall_s;
    logic                      new_v_s;

    // x0 is hard-wired zero, so it never has a producer
    function automatic logic prod_match(input logic v, input logic we,
                                        input logic [IDX_W-1:0] rd,
                                        input logic [IDX_W-1:0] rs);
        return v & we & (rd == rs) & (rs != {IDX_W{1'b0}});
    endfunction

    // Hazard detection, forward-select selection and next-state shift
    always_comb begin
        hit_s = 1'b0;
        sel_d = {(NUM_SRC*SEL_W){1'b0}};
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if ((k + 1 < LOAD_DATA_STG) && ld_q[k] &&
                    prod_match(v_q[k], we_q[k], rd_q[k], id_rs_idx[s*IDX_W +: IDX_W])) begin
                    hit_s = 1'b1;
                end else begin
                    hit_s = hit_s;
                end
            end
        end
        stall_s = ~flush & id_valid & hit_s;
        new_v_s = id_valid & ~stall_s & ~flush;

        // Scan oldest to youngest so the youngest producer overrides
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sel_d[s*SEL_W +: SEL_W] =
                    prod_match(v_q[k], we_q[k], rd_q[k], id_rs_idx[s*IDX_W +: IDX_W]) ?
                    SEL_W'(k) : sel_d[s*SEL_W +: SEL_W];
            end
        end
        if (!new_v_s) begin
            sel_d = {(NUM_SRC*SEL_W){1'b0}};
        end else begin
            sel_d = sel_d;
        end

        v_d[1]  = new_v_s;
        we_d[1] = id_rd_we;
        ld_d[1] = id_is_load;
        rd_d[1] = id_rd_idx;
        for (int k = 2; k <= DEPTH; k++) begin
            v_d[k]  = v_q[k-1] & ~(flush & (k == 2));
            we_d[k] = we_q[k-1];
            ld_d[k] = ld_q[k-1];
            rd_d[k] = rd_q[k-1];
        end

        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Tracker state, forward selects and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= {DEPTH{1'b0}};
            we_q  <= {DEPTH{1'b0}};
            ld_q  <= {DEPTH{1'b0}};
            rd_q  <= {(DEPTH*IDX_W){1'b0}};
            sel_q <= {(NUM_SRC*SEL_W){1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            v_q   <= v_d;
            we_q  <= we_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall      = stall_s;
    assign ex_valid   = v_q[1];
    assign ex_fwd_sel = sel_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_tracker.sv
// Bench for hazard_fwd_tracker: directed pipeline scenarios plus random traffic
// against an age-ordered queue model of in-flight instructions.
module tb_hazard_fwd_tracker;

    localparam int DEPTH = 3;
    localparam int LDS   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs_idx;
    logic [4:0]  id_rd_idx;
    logic        id_rd_we;
    logic        id_is_load;
    logic        flush;
    logic        stall, ex_valid;
    logic [3:0]  ex_fwd_sel;
    logic [15:0] stall_cnt;
    logic        stall2, ex_valid2;
    logic [3:0]  ex_fwd_sel2;
    logic [1:0]  stall_cnt2;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ent_t;

    ent_t pipe[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt;
    int   m_cnt2;
    bit   last_stall;

    always #5 clk = ~clk;

    hazard_fwd_tracker u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_idx(id_rs_idx),
        .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_fwd_sel(ex_fwd_sel), .stall_cnt(stall_cnt)
    );

    hazard_fwd_tracker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_idx(id_rs_idx),
        .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .flush(flush), .stall(stall2), .ex_valid(ex_valid2),
        .ex_fwd_sel(ex_fwd_sel2), .stall_cnt(stall_cnt2)
    );

    function automatic bit produces(ent_t e, bit [4:0] rs);
        return e.v && e.we && (e.rd == rs) && (rs != 5'd0);
    endfunction

    task automatic model_reset();
        ent_t b;
        b = '{1'b0, 5'd0, 1'b0, 1'b0};
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(b);
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; id_valid = 1'b0; id_rs_idx = 10'd0; id_rd_idx = 5'd0;
        id_rd_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One decode cycle: check comb stall, advance the model, check registered outputs
    task automatic step(input bit v, input bit [4:0] rs0, input bit [4:0] rs1,
                        input bit [4:0] rd, input bit we, input bit ld, input bit fl);
        bit [4:0] rs[2];
        bit       ms;
        ent_t     ne;
        bit [3:0] esel;
        id_valid = v; id_rs_idx = {rs1, rs0}; id_rd_idx = rd;
        id_rd_we = we; id_is_load = ld; flush = fl;
        rs[0] = rs0; rs[1] = rs1;
        #1;
        ms = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < pipe.size(); i++)
                if ((i + 2 < LDS) && pipe[i].ld && produces(pipe[i], rs[s])) ms = 1'b1;
        ms = ms && v && !fl;
        n_cmp++;
        if (stall !== ms) begin
            n_err++; $display("FAIL stall got %b exp %b", stall, ms);
        end
        last_stall = stall;
        ne = '{v && !ms && !fl, rd, we, ld};
        esel = 4'd0;
        if (ne.v)
            for (int s = 0; s < 2; s++)
                for (int i = DEPTH - 2; i >= 0; i--)
                    if (produces(pipe[i], rs[s])) esel[s*2 +: 2] = 2'(i + 1);
        if (fl) pipe[0].v = 1'b0;
        pipe.push_front(ne);
        void'(pipe.pop_back());
        if (ms) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ex_valid !== ne.v) begin
            n_err++; $display("FAIL ex_valid got %b exp %b", ex_valid, ne.v);
        end
        n_cmp++;
        if (ex_fwd_sel !== esel) begin
            n_err++; $display("FAIL ex_fwd_sel got %h exp %h", ex_fwd_sel, esel);
        end
        n_cmp++;
        if (stall_cnt !== 16'(m_cnt)) begin
            n_err++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, m_cnt);
        end
        n_cmp++;
        if (stall_cnt2 !== 2'(m_cnt2)) begin
            n_err++; $display("FAIL stall_cnt_sat got %0d exp %0d", stall_cnt2, m_cnt2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_valid = 1'b1; id_rs_idx = {5'd8, 5'd8}; id_rd_idx = 5'd9;
        id_rd_we = 1'b1; id_is_load = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({stall, ex_valid, ex_fwd_sel, stall_cnt, stall_cnt2} !== 24'd0) begin
            n_err++;
            $display("FAIL reset got %b/%b/%h/%0d/%0d exp 0/0/0/0/0",
                     stall, ex_valid, ex_fwd_sel, stall_cnt, stall_cnt2);
        end
        do_reset();
    endtask

    task automatic test_alu_chain();
        bit seen;
        do_reset();
        step(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        seen = last_stall;
        step(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        seen = seen | last_stall;
        n_cmp++;
        if (ex_fwd_sel !== 4'b0101 || seen) begin
            n_err++; $display("FAIL alu_chain got sel %h stall %b exp 5 0", ex_fwd_sel, seen);
        end
    endtask

    task automatic test_gap();
        do_reset();
        step(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ex_fwd_sel !== 4'b0010) begin
            n_err++; $display("FAIL gap got %h exp 2", ex_fwd_sel);
        end
    endtask

    task automatic test_load_use();
        bit first;
        do_reset();
        step(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
        first = last_stall;
        step(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (!first || last_stall || stall_cnt !== 16'd1 || ex_fwd_sel !== 4'b0010 || !ex_valid) begin
            n_err++;
            $display("FAIL load_use got stall %b,%b cnt %0d sel %h ev %b exp 1,0 1 2 1",
                     first, last_stall, stall_cnt, ex_fwd_sel, ex_valid);
        end
    endtask

    task automatic test_youngest();
        do_reset();
        step(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ex_fwd_sel !== 4'b0101) begin
            n_err++; $display("FAIL youngest got %h exp 5", ex_fwd_sel);
        end
    endtask

    task automatic test_flush_vs_stall();
        do_reset();
        step(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (last_stall || stall_cnt !== 16'd0 || ex_valid) begin
            n_err++;
            $display("FAIL flush_stall got stall %b cnt %0d ev %b exp 0 0 0",
                     last_stall, stall_cnt, ex_valid);
        end
        step(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000 || last_stall) begin
            n_err++; $display("FAIL flush_squash got sel %h stall %b exp 0 0", ex_fwd_sel, last_stall);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd5) begin
            n_err++; $display("FAIL saturation got %0d/%0d exp 3/5", stall_cnt2, stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        id_valid = 1'b1; id_rs_idx = {5'd0, 5'd8}; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stall, ex_valid, ex_fwd_sel, stall_cnt} !== 22'd0) begin
            n_err++;
            $display("FAIL async_reset got %b/%b/%h/%0d exp 0/0/0/0",
                     stall, ex_valid, ex_fwd_sel, stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_chain();
        test_gap();
        test_load_use();
        test_youngest();
        test_flush_vs_stall();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
